// File: rtl/responder_arbiter_if.sv
// -----------------------------------------------------------------------------
// responder_arbiter_if
// Bundles the host-facing and player-facing signals of the quiz responder
// arbiter.
//   master : host/testbench side, drives Start, Clear and Keys and observes the
//            winner, buzzer and timer outputs.
//   slave  : the arbiter itself.
// Signals:
//   Start         round enable, level
//   Clear         single-cycle re-arm pulse
//   Keys          player keys, active-low, asynchronous to CLK
//   LED_Out       one-hot winner LED
//   Player_Number winner index + 1, 0 = none
//   Buzzer        buzzer drive, high = sounding
//   Time_Left     seconds remaining in the answer window
//   Time_Up       high while the answer window has expired
//   Busy          high while a winner is locked or timed out
//   Disq_Mask     false-start disqualify mask (only with RESPONDER_FALSE_START_EN)
// -----------------------------------------------------------------------------
interface responder_arbiter_if #(
   parameter int N_PLAYERS = 8,
   parameter int PNUM_W    = 4
);

   logic                 Start;
   logic                 Clear;
   logic [N_PLAYERS-1:0] Keys;
   logic [N_PLAYERS-1:0] LED_Out;
   logic [PNUM_W-1:0]    Player_Number;
   logic                 Buzzer;
   logic [7:0]           Time_Left;
   logic                 Time_Up;
   logic                 Busy;
`ifdef RESPONDER_FALSE_START_EN
   logic [N_PLAYERS-1:0] Disq_Mask;

   modport master (
      output Start, Clear, Keys,
      input  LED_Out, Player_Number, Buzzer, Time_Left, Time_Up, Busy, Disq_Mask
   );

   modport slave (
      input  Start, Clear, Keys,
      output LED_Out, Player_Number, Buzzer, Time_Left, Time_Up, Busy, Disq_Mask
   );
`else
   modport master (
      output Start, Clear, Keys,
      input  LED_Out, Player_Number, Buzzer, Time_Left, Time_Up, Busy
   );

   modport slave (
      input  Start, Clear, Keys,
      output LED_Out, Player_Number, Buzzer, Time_Left, Time_Up, Busy
   );
`endif

endinterface

// File: rtl/responder_arbiter.sv
// -----------------------------------------------------------------------------
// responder_arbiter
// N-player quiz responder. After Start, the first pressed key wins (lowest
// index on a tie), every other key is locked out. The winner's LED and number
// are shown, a buzzer pulse of BUZZ_CYCLES cycles is sounded, and an answer
// window of ANSWER_SECS seconds counts down. When it expires the buzzer pulses
// again and Time_Up is raised. Clear re-arms for the next question; dropping
// Start returns to idle with every output cleared.
//
// Ports:
//   CLK   system clock
//   Rstn  asynchronous active-low reset
//   bus   responder_arbiter_if.slave (Start, Clear, Keys in; LED_Out,
//         Player_Number, Buzzer, Time_Left, Time_Up, Busy [, Disq_Mask] out)
//
// Optional feature macro: RESPONDER_FALSE_START_EN
//   When defined, keys pressed while Start is low disqualify their player for
//   the following round; the mask is exposed on bus.Disq_Mask and is cleared
//   by reset or by the Start 1->0 transition that ends a round.
// -----------------------------------------------------------------------------
module responder_arbiter #(
   parameter int N_PLAYERS   = 8,
   parameter int PNUM_W      = 4,
   parameter int BUZZ_CYCLES = 25_000_000,
   parameter int SEC_CYCLES  = 50_000_000,
   parameter int ANSWER_SECS = 30
) (
   input  logic                CLK,
   input  logic                Rstn,
   responder_arbiter_if.slave  bus
);

   // Counter widths; a one-cycle period still needs a one-bit counter.
   localparam int BUZZ_W = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
   localparam int SEC_W  = (SEC_CYCLES  > 1) ? $clog2(SEC_CYCLES)  : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_t;

   state_t               state_r;
   logic [N_PLAYERS-1:0] key_meta_r;
   logic [N_PLAYERS-1:0] key_sync_r;
   logic [N_PLAYERS-1:0] pressed_s;
   logic [N_PLAYERS-1:0] cand_s;
   logic [N_PLAYERS-1:0] grant_onehot_s;
   logic [PNUM_W-1:0]    grant_num_s;
   logic                 any_cand_s;
   logic                 buzz_last_s;
   logic                 sec_tick_s;

   logic [BUZZ_W-1:0]    buzz_cnt_r;
   logic [SEC_W-1:0]     sec_cnt_r;
   logic [N_PLAYERS-1:0] led_r;
   logic [PNUM_W-1:0]    pnum_r;
   logic                 buzzer_r;
   logic [7:0]           time_left_r;
   logic                 time_up_r;
   logic                 busy_r;

   // Index of the lowest set bit; scanning downward lets the lowest index win.
   function automatic logic [PNUM_W-1:0] lowest_idx(input logic [N_PLAYERS-1:0] vec);
      logic [PNUM_W-1:0] idx;
      idx = '0;
      for (int i = N_PLAYERS - 1; i >= 0; i--) begin
         idx = vec[i] ? PNUM_W'(i) : idx;
      end
      return idx;
   endfunction

   // Two-flop synchroniser; resets to the released (high) key level so that
   // no phantom press appears right after reset.
   always_ff @(posedge CLK or negedge Rstn) begin
      if (!Rstn) begin
         key_meta_r <= '1;
         key_sync_r <= '1;
      end else begin
         key_meta_r <= bus.Keys;
         key_sync_r <= key_meta_r;
      end
   end

   assign pressed_s = ~key_sync_r;

`ifdef RESPONDER_FALSE_START_EN
   logic [N_PLAYERS-1:0] disq_r;
   logic                 start_d_r;

   // False-start mask: collects presses made while idle with Start low and is
   // wiped when a round ends (Start falling).
   always_ff @(posedge CLK or negedge Rstn) begin
      if (!Rstn) begin
         disq_r    <= '0;
         start_d_r <= 1'b0;
      end else begin
         start_d_r <= bus.Start;
         if (start_d_r && !bus.Start) begin
            disq_r <= '0;
         end else if ((state_r == ST_IDLE) && !bus.Start) begin
            disq_r <= disq_r | pressed_s;
         end else begin
            disq_r <= disq_r;
         end
      end
   end

   assign cand_s        = pressed_s & ~disq_r;
   assign bus.Disq_Mask = disq_r;
`else
   assign cand_s = pressed_s;
`endif

   // Two's-complement trick isolates the lowest set bit as the one-hot grant.
   assign grant_onehot_s = cand_s & (~cand_s + N_PLAYERS'(1));
   assign grant_num_s    = lowest_idx(cand_s) + PNUM_W'(1);
   assign any_cand_s     = |cand_s;
   assign buzz_last_s    = (buzz_cnt_r == BUZZ_W'(BUZZ_CYCLES - 1));
   assign sec_tick_s     = (sec_cnt_r == SEC_W'(SEC_CYCLES - 1));

   // Main state machine with all outputs registered. Start low overrides
   // everything, then Clear, then key arbitration.
   always_ff @(posedge CLK or negedge Rstn) begin
      if (!Rstn) begin
         state_r     <= ST_IDLE;
         buzz_cnt_r  <= '0;
         sec_cnt_r   <= '0;
         led_r       <= '0;
         pnum_r      <= '0;
         buzzer_r    <= 1'b0;
         time_left_r <= 8'd0;
         time_up_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else if (!bus.Start) begin
         state_r     <= ST_IDLE;
         buzz_cnt_r  <= '0;
         sec_cnt_r   <= '0;
         led_r       <= '0;
         pnum_r      <= '0;
         buzzer_r    <= 1'b0;
         time_left_r <= 8'd0;
         time_up_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_r    <= ST_ARMED;
               buzz_cnt_r <= '0;
               sec_cnt_r  <= '0;
            end

            ST_ARMED: begin
               // No edge requirement: a key still held on re-arm wins at once.
               if (any_cand_s) begin
                  state_r     <= ST_LOCKED;
                  led_r       <= grant_onehot_s;
                  pnum_r      <= grant_num_s;
                  buzzer_r    <= 1'b1;
                  buzz_cnt_r  <= '0;
                  time_left_r <= 8'(ANSWER_SECS);
                  sec_cnt_r   <= '0;
                  busy_r      <= 1'b1;
               end else begin
                  state_r <= ST_ARMED;
               end
            end

            ST_LOCKED: begin
               if (bus.Clear) begin
                  state_r     <= ST_ARMED;
                  buzz_cnt_r  <= '0;
                  sec_cnt_r   <= '0;
                  led_r       <= '0;
                  pnum_r      <= '0;
                  buzzer_r    <= 1'b0;
                  time_left_r <= 8'd0;
                  time_up_r   <= 1'b0;
                  busy_r      <= 1'b0;
               end else begin
                  // Buzz counter saturates at its last value once the pulse ends.
                  if (buzzer_r) begin
                     if (buzz_last_s) begin
                        buzzer_r <= 1'b0;
                     end else begin
                        buzz_cnt_r <= buzz_cnt_r + BUZZ_W'(1);
                     end
                  end else begin
                     buzzer_r <= 1'b0;
                  end
                  if (sec_tick_s) begin
                     sec_cnt_r <= '0;
                     if (time_left_r == 8'd1) begin
                        // Window expired: restart the buzz pulse for the alarm.
                        state_r     <= ST_TIMEOUT;
                        time_left_r <= 8'd0;
                        time_up_r   <= 1'b1;
                        buzzer_r    <= 1'b1;
                        buzz_cnt_r  <= '0;
                     end else begin
                        time_left_r <= time_left_r - 8'd1;
                     end
                  end else begin
                     sec_cnt_r <= sec_cnt_r + SEC_W'(1);
                  end
               end
            end

            ST_TIMEOUT: begin
               if (bus.Clear) begin
                  state_r     <= ST_ARMED;
                  buzz_cnt_r  <= '0;
                  sec_cnt_r   <= '0;
                  led_r       <= '0;
                  pnum_r      <= '0;
                  buzzer_r    <= 1'b0;
                  time_left_r <= 8'd0;
                  time_up_r   <= 1'b0;
                  busy_r      <= 1'b0;
               end else if (buzzer_r) begin
                  if (buzz_last_s) begin
                     buzzer_r <= 1'b0;
                  end else begin
                     buzz_cnt_r <= buzz_cnt_r + BUZZ_W'(1);
                  end
               end else begin
                  buzzer_r <= 1'b0;
               end
            end

            default: begin
               state_r     <= ST_IDLE;
               buzz_cnt_r  <= '0;
               sec_cnt_r   <= '0;
               led_r       <= '0;
               pnum_r      <= '0;
               buzzer_r    <= 1'b0;
               time_left_r <= 8'd0;
               time_up_r   <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.LED_Out       = led_r;
   assign bus.Player_Number = pnum_r;
   assign bus.Buzzer        = buzzer_r;
   assign bus.Time_Left     = time_left_r;
   assign bus.Time_Up       = time_up_r;
   assign bus.Busy          = busy_r;

endmodule

// File: tb/tb_responder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_responder_arbiter
// Directed bench for responder_arbiter with N_PLAYERS=8, BUZZ_CYCLES=4,
// SEC_CYCLES=10, ANSWER_SECS=3. Inputs change 2 time units after a rising
// edge and outputs are checked at that same point, well away from the edge.
// -----------------------------------------------------------------------------
module tb_responder_arbiter;

   logic clk;
   logic rstn;
   int   n_cmp;
   int   n_bad;

   responder_arbiter_if #(.N_PLAYERS(8), .PNUM_W(4)) bus ();

   responder_arbiter #(
      .N_PLAYERS  (8),
      .PNUM_W     (4),
      .BUZZ_CYCLES(4),
      .SEC_CYCLES (10),
      .ANSWER_SECS(3)
   ) dut (
      .CLK (clk),
      .Rstn(rstn),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_led"},  32'(bus.LED_Out),       32'h0);
      check({tag, "_pnum"}, 32'(bus.Player_Number), 32'h0);
      check({tag, "_buzz"}, 32'(bus.Buzzer),        32'h0);
      check({tag, "_tl"},   32'(bus.Time_Left),     32'h0);
      check({tag, "_tup"},  32'(bus.Time_Up),       32'h0);
      check({tag, "_busy"}, 32'(bus.Busy),          32'h0);
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rstn      = 1'b0;
      bus.Start = 1'b0;
      bus.Clear = 1'b0;
      bus.Keys  = 8'hFF;
      tick(2);
      check_idle_outputs("reset");
`ifdef RESPONDER_FALSE_START_EN
      check("reset_disq", 32'(bus.Disq_Mask), 32'h0);
`endif
      rstn = 1'b1;
      tick(1);

`ifdef RESPONDER_FALSE_START_EN
      // False start: key 1 pressed while Start is low.
      bus.Keys = 8'hFD;
      tick(3);
      check("fs_disq", 32'(bus.Disq_Mask), 32'h02);
      bus.Keys  = 8'hFF;
      bus.Start = 1'b1;
      tick(1);
      bus.Keys = 8'hED;
      tick(3);
      check("fs_pnum", 32'(bus.Player_Number), 32'd5);
      check("fs_led",  32'(bus.LED_Out),       32'h10);
      bus.Keys  = 8'hFF;
      bus.Start = 1'b0;
      tick(1);
      check("fs_disq_clr", 32'(bus.Disq_Mask), 32'h0);
      check_idle_outputs("fs_idle");
      tick(2);
`endif

      // Single press of key 5: three-cycle latency, four-cycle buzz.
      bus.Start = 1'b1;
      tick(1);
      bus.Keys = 8'hDF;
      tick(2);
      check("k5_latency_led", 32'(bus.LED_Out), 32'h0);
      tick(1);
      check("k5_led",  32'(bus.LED_Out),       32'h20);
      check("k5_pnum", 32'(bus.Player_Number), 32'd6);
      check("k5_buzz", 32'(bus.Buzzer),        32'h1);
      check("k5_busy", 32'(bus.Busy),          32'h1);
      check("k5_tl",   32'(bus.Time_Left),     32'd3);
      for (int k = 1; k <= 3; k++) begin
         tick(1);
         check("k5_buzz_hold", 32'(bus.Buzzer), 32'h1);
      end
      tick(1);
      check("k5_buzz_end", 32'(bus.Buzzer), 32'h0);

      // Clear in LOCKED after keys released, then key 7 wins.
      bus.Keys = 8'hFF;
      tick(2);
      bus.Clear = 1'b1;
      tick(1);
      bus.Clear = 1'b0;
      check_idle_outputs("clr_locked");
      bus.Keys = 8'h7F;
      tick(3);
      check("k7_pnum", 32'(bus.Player_Number), 32'd8);
      check("k7_led",  32'(bus.LED_Out),       32'h80);
      bus.Keys = 8'hFF;
      tick(2);
      bus.Clear = 1'b1;
      tick(1);
      bus.Clear = 1'b0;
      check("clr2_busy", 32'(bus.Busy), 32'h0);

      // Simultaneous keys 2 and 6 -> lowest index wins; later key 0 ignored.
      bus.Keys = 8'hBB;
      tick(3);
      check("sim_pnum", 32'(bus.Player_Number), 32'd3);
      check("sim_led",  32'(bus.LED_Out),       32'h04);
      bus.Keys = 8'hBA;
      tick(3);
      check("late_pnum", 32'(bus.Player_Number), 32'd3);
      check("late_led",  32'(bus.LED_Out),       32'h04);

      // Countdown: grant was 3 cycles ago; seconds tick every 10 cycles.
      tick(6);
      check("cd_tl3", 32'(bus.Time_Left), 32'd3);
      tick(1);
      check("cd_tl2", 32'(bus.Time_Left), 32'd2);
      check("cd_buzz_off", 32'(bus.Buzzer), 32'h0);
      tick(9);
      check("cd_tl2_hold", 32'(bus.Time_Left), 32'd2);
      tick(1);
      check("cd_tl1", 32'(bus.Time_Left), 32'd1);
      tick(9);
      check("cd_tl1_hold", 32'(bus.Time_Left), 32'd1);
      check("cd_tup_pre",  32'(bus.Time_Up),   32'h0);
      tick(1);
      check("to_tl0",  32'(bus.Time_Left),     32'd0);
      check("to_tup",  32'(bus.Time_Up),       32'h1);
      check("to_buzz", 32'(bus.Buzzer),        32'h1);
      check("to_led",  32'(bus.LED_Out),       32'h04);
      check("to_pnum", 32'(bus.Player_Number), 32'd3);
      check("to_busy", 32'(bus.Busy),          32'h1);
      for (int k = 1; k <= 3; k++) begin
         tick(1);
         check("to_buzz_hold", 32'(bus.Buzzer), 32'h1);
      end
      tick(1);
      check("to_buzz_end", 32'(bus.Buzzer), 32'h0);

      // Clear in TIMEOUT with key 0 still held: re-armed, then key 0 wins at once.
      bus.Clear = 1'b1;
      tick(1);
      bus.Clear = 1'b0;
      check_idle_outputs("clr_timeout");
      tick(1);
      check("held_pnum", 32'(bus.Player_Number), 32'd1);
      check("held_led",  32'(bus.LED_Out),       32'h01);
      check("held_busy", 32'(bus.Busy),          32'h1);
      bus.Keys = 8'hFF;

      // Start dropped together with Clear mid-LOCKED -> IDLE.
      tick(1);
      bus.Start = 1'b0;
      bus.Clear = 1'b1;
      tick(1);
      bus.Clear = 1'b0;
      check_idle_outputs("start_drop");
      tick(1);
      check("idle_hold_busy", 32'(bus.Busy), 32'h0);

      // Asynchronous reset mid-buzz.
      bus.Start = 1'b1;
      tick(1);
      bus.Keys = 8'hF7;
      tick(3);
      check("k3_pnum", 32'(bus.Player_Number), 32'd4);
      tick(1);
      check("k3_buzz", 32'(bus.Buzzer), 32'h1);
      #1;
      rstn = 1'b0;
      #1;
      check_idle_outputs("async_rst");
      bus.Keys  = 8'hFF;
      bus.Start = 1'b0;
      tick(1);
      rstn = 1'b1;
      tick(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
